// File: rtl/bit_serializer_pkg.sv
// Shared definitions for the serial path.
//   ser_state_t : serializer FSM state encoding
//   GAP_CW      : width of the inter-frame gap counter (gaps of 0..15 cycles)
//   ser_clog2   : ceiling log2 for sizing counters; never returns less than 1
package bit_serializer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_GAP   = 2'b10
   } ser_state_t;

   localparam int GAP_CW = 4;

   function automatic int ser_clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      if (r < 1) r = 1;
      return r;
   endfunction

endpackage

// File: rtl/bit_serializer_frame_bit_counter.sv
// Bit position counter for one serialized frame.
//   clk, reset : clock and asynchronous active-high reset
//   clear      : return the count to 0 (takes priority over inc)
//   inc        : advance one bit position
//   last       : count is on the final bit of the frame (WIDTH-1)
module frame_bit_counter
   import bit_serializer_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic inc,
   output logic last
);

   localparam int CW = ser_clog2(WIDTH);

   logic [CW-1:0] count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         count <= '0;
      else if (clear)
         count <= '0;
      else if (inc)
         count <= count + 1'b1;
   end

   assign last = (count == CW'(WIDTH - 1));

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial stage feeding the serial sequence detectors.
// Words arrive over valid/ready and leave one bit per clock, with a
// one-word hold buffer so consecutive frames run without a bubble.
//   clk, reset  : clock and asynchronous active-high reset
//   load_data   : word to serialize
//   load_valid  : load_data is valid
//   load_ready  : a word can be accepted (hold buffer empty)
//   dout        : serial bit, forced 0 when not valid
//   dout_valid  : dout carries a frame bit
//   frame_done  : pulse with the last bit of each frame
//   busy        : FSM active or a word is held
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no frame in flight; outputs idle zeros
// ST_SHIFT | emitting one bit per clock from the shift register
// ST_GAP   | GAP_CYCLES idle cycles between frames
module bit_serializer
   import bit_serializer_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter bit MSB_FIRST  = 1'b1,
   parameter int GAP_CYCLES = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] load_data,
   input  logic             load_valid,
   output logic             load_ready,
   output logic             dout,
   output logic             dout_valid,
   output logic             frame_done,
   output logic             busy
);

   localparam logic [GAP_CW-1:0] GAP_LAST =
      (GAP_CYCLES > 0) ? GAP_CW'(GAP_CYCLES - 1) : '0;

   ser_state_t        state;
   logic [WIDTH-1:0]  shift_q;
   logic [WIDTH-1:0]  hold_q;
   logic              hold_full;
   logic [GAP_CW-1:0] gap_cnt;
   logic              bit_last;
   logic              accept;
   logic              cur_bit;
   logic [WIDTH-1:0]  shift_next;

   assign load_ready = !hold_full;
   assign accept     = load_valid && load_ready;
   assign busy       = (state != ST_IDLE) || hold_full;

   assign cur_bit    = MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0];
   assign shift_next = MSB_FIRST ? {shift_q[WIDTH-2:0], 1'b0}
                                 : {1'b0, shift_q[WIDTH-1:1]};

   // Held at zero outside SHIFT and cleared on the last bit, so every
   // frame starts from position 0 regardless of how it was loaded.
   frame_bit_counter #(
      .WIDTH (WIDTH)
   ) u_bit_cnt (
      .clk   (clk),
      .reset (reset),
      .clear ((state != ST_SHIFT) || bit_last),
      .inc   (state == ST_SHIFT),
      .last  (bit_last)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ST_IDLE;
         shift_q    <= '0;
         hold_q     <= '0;
         hold_full  <= 1'b0;
         gap_cnt    <= '0;
         dout       <= 1'b0;
         dout_valid <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         dout       <= 1'b0;
         dout_valid <= 1'b0;
         frame_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (hold_full) begin
                  shift_q   <= hold_q;
                  hold_full <= 1'b0;
                  state     <= ST_SHIFT;
               end else if (accept) begin
                  shift_q <= load_data;
                  state   <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               dout       <= cur_bit;
               dout_valid <= 1'b1;
               frame_done <= bit_last;
               shift_q    <= shift_next;
               if (bit_last) begin
                  if (GAP_CYCLES > 0) begin
                     state   <= ST_GAP;
                     gap_cnt <= '0;
                     if (accept) begin
                        hold_q    <= load_data;
                        hold_full <= 1'b1;
                     end
                  end else if (hold_full) begin
                     shift_q   <= hold_q;
                     hold_full <= 1'b0;
                  end else if (accept) begin
                     // hold is empty, so the new word skips it entirely
                     shift_q <= load_data;
                  end else begin
                     state <= ST_IDLE;
                  end
               end else if (accept) begin
                  hold_q    <= load_data;
                  hold_full <= 1'b1;
               end
            end
            ST_GAP: begin
               if (gap_cnt == GAP_LAST) begin
                  if (hold_full) begin
                     shift_q   <= hold_q;
                     hold_full <= 1'b0;
                     state     <= ST_SHIFT;
                  end else if (accept) begin
                     shift_q <= load_data;
                     state   <= ST_SHIFT;
                  end else begin
                     state <= ST_IDLE;
                  end
               end else begin
                  gap_cnt <= gap_cnt + 1'b1;
                  if (accept) begin
                     hold_q    <= load_data;
                     hold_full <= 1'b1;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: reset, single word, back-to-back,
// backpressure, abort, LSB-first and gap variants, and a random stream
// whose reassembled words are compared against the accepted words.
module tb_bit_serializer;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] load_data;
   logic       lv0, lv1, lv2;
   logic       rdy0, dout0, dv0, fd0, busy0;
   logic       rdy1, dout1, dv1, fd1, busy1;
   logic       rdy2, dout2, dv2, fd2, busy2;

   int checks = 0;
   int errors = 0;

   logic [7:0] expq[$];
   logic [7:0] rxq[$];
   logic [7:0] acc = '0;
   int         acc_n = 0;

   always #5 clk = ~clk;

   bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP_CYCLES(0)) u_dut (
      .clk(clk), .reset(reset), .load_data(load_data), .load_valid(lv0),
      .load_ready(rdy0), .dout(dout0), .dout_valid(dv0),
      .frame_done(fd0), .busy(busy0)
   );

   bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .GAP_CYCLES(0)) u_lsb (
      .clk(clk), .reset(reset), .load_data(load_data), .load_valid(lv1),
      .load_ready(rdy1), .dout(dout1), .dout_valid(dv1),
      .frame_done(fd1), .busy(busy1)
   );

   bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP_CYCLES(2)) u_gap (
      .clk(clk), .reset(reset), .load_data(load_data), .load_valid(lv2),
      .load_ready(rdy2), .dout(dout2), .dout_valid(dv2),
      .frame_done(fd2), .busy(busy2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reassembles MSB-first frames from the default instance.
   always @(negedge clk) begin
      if (reset) begin
         acc_n = 0;
         acc   = '0;
      end else if (dv0) begin
         acc = {acc[6:0], dout0};
         acc_n++;
         chk("mon_frame_done", fd0, (acc_n == 8));
         if (acc_n == 8) begin
            rxq.push_back(acc);
            acc_n = 0;
         end
      end else begin
         chk("mon_idle_dout", dout0, 0);
         chk("mon_idle_fd", fd0, 0);
      end
   end

   task automatic send(input logic [7:0] w);
      int n;
      @(negedge clk);
      load_data = w;
      lv0 = 1'b1;
      n = 0;
      while (!rdy0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("send_ready", rdy0, 1);
      if (rdy0) begin
         @(posedge clk);
         expq.push_back(w);
         #1;
      end
      lv0 = 1'b0;
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      while ((busy0 || dv0 || rxq.size() != expq.size()) && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_count"}, rxq.size(), expq.size());
      for (int i = 0; i < expq.size() && i < rxq.size(); i++)
         chk({tag, "_word"}, rxq[i], expq[i]);
      expq.delete();
      rxq.delete();
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0]  w;
      logic [7:0]  wa, wb;
      logic [15:0] pat;
      int          n;

      reset = 1'b1; lv0 = 1'b0; lv1 = 1'b0; lv2 = 1'b0; load_data = '0;
      repeat (2) @(negedge clk);
      chk("rst_ready", rdy0, 1);
      chk("rst_dout", dout0, 0);
      chk("rst_valid", dv0, 0);
      chk("rst_fd", fd0, 0);
      chk("rst_busy", busy0, 0);
      @(negedge clk); #2 reset = 1'b0;

      // single word, MSB first
      w = 8'hB0;
      send(w);
      chk("t2_busy", busy0, 1);
      @(negedge clk);
      chk("t2_latency", dv0, 0);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("t2_bit", dout0, w[7-i]);
         chk("t2_valid", dv0, 1);
         chk("t2_fd", fd0, (i == 7));
      end
      @(negedge clk);
      chk("t2_valid_end", dv0, 0);
      drain("t2");
      chk("t2_idle_busy", busy0, 0);

      // back-to-back, no bubble
      pat = 16'hA53C;
      send(8'hA5);
      send(8'h3C);
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         chk("t3_bit", dout0, pat[15-i]);
         chk("t3_valid", dv0, 1);
         chk("t3_fd", fd0, (i == 7 || i == 15));
      end
      @(negedge clk);
      chk("t3_valid_end", dv0, 0);
      drain("t3");

      // backpressure: third word waits for the hold to drain
      send(8'h11);
      send(8'h22);
      @(negedge clk);
      chk("t4_ready_low", rdy0, 0);
      load_data = 8'h33;
      lv0 = 1'b1;
      n = 0;
      while (!rdy0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("t4_wait_cycles", n, 7);
      chk("t4_ready_high", rdy0, 1);
      @(posedge clk);
      expq.push_back(8'h33);
      #1 lv0 = 1'b0;
      @(negedge clk);
      chk("t4_ready_low2", rdy0, 0);
      drain("t4");

      // abort mid-frame with asynchronous reset
      send(8'hFF);
      repeat (4) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("t5_valid", dv0, 0);
      chk("t5_dout", dout0, 0);
      chk("t5_fd", fd0, 0);
      chk("t5_busy", busy0, 0);
      chk("t5_ready", rdy0, 1);
      void'(expq.pop_back());
      @(negedge clk); #2 reset = 1'b0;
      send(8'h0F);
      drain("t5");

      // LSB first
      @(negedge clk);
      load_data = 8'h01;
      lv1 = 1'b1;
      chk("t6_lsb_ready", rdy1, 1);
      @(posedge clk);
      #1 lv1 = 1'b0;
      @(negedge clk);
      chk("t6_lsb_latency", dv1, 0);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("t6_lsb_bit", dout1, (i == 0));
         chk("t6_lsb_valid", dv1, 1);
         chk("t6_lsb_fd", fd1, (i == 7));
      end
      @(negedge clk);
      chk("t6_lsb_end", dv1, 0);
      chk("t6_lsb_busy", busy1, 0);

      // two idle cycles between frames
      wa = 8'hC3;
      wb = 8'h81;
      @(negedge clk);
      load_data = wa;
      lv2 = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      load_data = wb;
      chk("t6_gap_ready", rdy2, 1);
      @(posedge clk);
      #1 lv2 = 1'b0;
      for (int i = 0; i < 18; i++) begin
         @(negedge clk);
         if (i < 8) begin
            chk("t6_gap_bit_a", dout2, wa[7-i]);
            chk("t6_gap_valid_a", dv2, 1);
         end else if (i < 10) begin
            chk("t6_gap_idle_dout", dout2, 0);
            chk("t6_gap_idle_valid", dv2, 0);
         end else begin
            chk("t6_gap_bit_b", dout2, wb[17-i]);
            chk("t6_gap_valid_b", dv2, 1);
         end
         chk("t6_gap_fd", fd2, (i == 7 || i == 17));
      end
      repeat (3) @(negedge clk);
      chk("t6_gap_end_valid", dv2, 0);
      chk("t6_gap_busy", busy2, 0);

      // random stream
      for (int k = 0; k < 1000; k++) begin
         w = 8'($urandom);
         send(w);
         if ($urandom_range(0, 3) == 0)
            repeat ($urandom_range(1, 10)) @(negedge clk);
      end
      drain("rand");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
